// File: rtl/dot_product_vec.sv
// dot_product_vec: memory-fed multi-lane dot product with masked tail, signed/unsigned mode and saturating or wrapping accumulator
module dot_product_vec #(
    parameter int DATA_W     = 32,
    parameter int ACC_W      = 64,
    parameter int ADDR_WIDTH = 4,
    parameter int LANES      = 2,
    parameter int SATURATE   = 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              start_mm,
    input  logic                              ack_ticks,
    input  logic                              signed_mode,
    input  logic [ADDR_WIDTH-1:0]             base_addr,
    input  logic [ADDR_WIDTH+$clog2(LANES):0] len,
    input  logic [LANES*DATA_W-1:0]           q_a,
    input  logic [LANES*DATA_W-1:0]           q_b,
    output logic [ADDR_WIDTH-1:0]             address,
    output logic [ACC_W-1:0]                  acc,
    output logic                              ovf,
    output logic                              busy,
    output logic                              dp_done
);
    localparam int L2 = $clog2(LANES);
    localparam int LW = ADDR_WIDTH + L2 + 1;
    localparam int NW = ADDR_WIDTH + 1;
    localparam int PW = 2 * DATA_W + L2;
    localparam int EW = (ACC_W > PW ? ACC_W : PW) + 2;
    localparam logic [LW-1:0] LMAX = LW'(LANES << ADDR_WIDTH);
    localparam logic signed [EW-1:0] SMAX = {{(EW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [EW-1:0] SMIN = {{(EW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic signed [EW-1:0] UMAX = {{(EW-ACC_W){1'b0}}, {ACC_W{1'b1}}};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARM      = 3'd1,
        S_RUN      = 3'd2,
        S_DRAIN    = 3'd3,
        S_DONE     = 3'd4,
        S_WAIT_ACK = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [NW-1:0]         i_q, i_d;
    logic [NW-1:0]         nwords_q, nwords_d;
    logic [LW-1:0]         len_q, len_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic                  sm_q, sm_d;
    logic                  valid_q, valid_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic                  ovf_q, ovf_d;

    logic                  accept, issue;
    logic [LW-1:0]         len_c;
    logic [NW-1:0]         nwords_new;
    logic [NW-1:0]         widx;
    logic signed [EW-1:0]  prod [LANES];
    logic signed [EW-1:0]  sum, acc_e, total;
    logic                  hi, lo;
    logic [ACC_W-1:0]      sat_val, acc_new;

    assign accept     = (state_q == S_ARM) && start_mm;
    assign issue      = (state_q == S_RUN) && (i_q < nwords_q);
    assign len_c      = (len > LMAX) ? LMAX : len;
    assign nwords_new = NW'((len_c + LW'(LANES - 1)) >> L2);
    assign widx       = i_q - NW'(1);

    // The word being returned is the one issued on the previous edge, so its index is i-1.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic signed [EW-1:0] a_e, b_e;
        logic [LW-1:0]        elem;
        assign a_e     = {{(EW-DATA_W){sm_q & q_a[g*DATA_W+DATA_W-1]}}, q_a[g*DATA_W +: DATA_W]};
        assign b_e     = {{(EW-DATA_W){sm_q & q_b[g*DATA_W+DATA_W-1]}}, q_b[g*DATA_W +: DATA_W]};
        assign elem    = (LW'(widx) << L2) + LW'(g);
        assign prod[g] = (elem < len_q) ? a_e * b_e : '0;
    end

    // Lossless lane sum plus accumulator in a widened domain, then range check and clamp or wrap.
    always_comb begin
        sum = '0;
        for (int k = 0; k < LANES; k++) sum = sum + prod[k];
        acc_e   = {{(EW-ACC_W){sm_q & acc_q[ACC_W-1]}}, acc_q};
        total   = acc_e + sum;
        hi      = sm_q ? (total > SMAX) : (total > UMAX);
        lo      = sm_q & (total < SMIN);
        sat_val = sm_q ? (hi ? {1'b0, {(ACC_W-1){1'b1}}} : {1'b1, {(ACC_W-1){1'b0}}}) : {ACC_W{1'b1}};
        acc_new = ((hi | lo) && SATURATE != 0) ? sat_val : total[ACC_W-1:0];
    end

    // Run setup on start accept, word index advance on issue, accumulate on returned valid words.
    always_comb begin
        i_d      = i_q;
        nwords_d = nwords_q;
        len_d    = len_q;
        base_d   = base_q;
        sm_d     = sm_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        valid_d  = issue;
        if (accept) begin
            i_d      = '0;
            acc_d    = '0;
            ovf_d    = 1'b0;
            sm_d     = signed_mode;
            base_d   = base_addr;
            len_d    = len_c;
            nwords_d = nwords_new;
        end else begin
            if (issue) i_d = i_q + NW'(1);
            if (valid_q) begin
                acc_d = acc_new;
                ovf_d = ovf_q | hi | lo;
            end
        end
    end

    // Control FSM next state: level handshakes on start and ack, illegal codes recover to IDLE.
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE:     state_d = start_mm ? S_IDLE : S_ARM;
            S_ARM:      state_d = start_mm ? S_RUN : S_ARM;
            S_RUN:      state_d = (nwords_q == '0) ? S_DONE : (i_q == nwords_q - NW'(1)) ? S_DRAIN : S_RUN;
            S_DRAIN:    state_d = S_DONE;
            S_DONE:     state_d = ack_ticks ? S_DONE : S_WAIT_ACK;
            S_WAIT_ACK: state_d = ack_ticks ? S_IDLE : S_WAIT_ACK;
            default:    state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            nwords_q <= '0;
            len_q    <= '0;
            base_q   <= '0;
            sm_q     <= 1'b0;
            valid_q  <= 1'b0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            nwords_q <= nwords_d;
            len_q    <= len_d;
            base_q   <= base_d;
            sm_q     <= sm_d;
            valid_q  <= valid_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
        end
    end

    // Outputs decoded from state and registered datapath.
    always_comb begin
        busy    = (state_q == S_RUN) || (state_q == S_DRAIN);
        dp_done = (state_q == S_DONE) || (state_q == S_WAIT_ACK);
        address = base_q + i_q[ADDR_WIDTH-1:0];
        acc     = acc_q;
        ovf     = ovf_q;
    end
endmodule
